operand_entry: RTL and testbench

- Sequential front end for the add/sub calculator.
- Lets the user key in two signed decimal operands, digit by digit, from switches and one pushbutton.
- Converts each operand from sign + two BCD digits into a W-bit two's-complement value. This is the inverse of the existing binary → sign-magnitude → BCD → segment display path.
- Feeds operands A and B to the adder/subtractor. Exposes entry stage and partial digits so the hex displays can prompt the user.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/operand_entry_if.sv | 13 +
 rtl/press_detect.sv | 30 +++
 rtl/operand_entry.sv | 137 +++++++++++++
 tb/tb_operand_entry.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and limits for the calculator datapath: operand entry FSM
// states and the signed-magnitude bounds of a W-bit two's-complement operand.
package calc_pkg;

    typedef enum logic [2:0] {
        A_TENS = 3'd0,
        A_ONES = 3'd1,
        B_TENS = 3'd2,
        B_ONES = 3'd3,
        DONE   = 3'd4
    } entry_state_t;

    localparam int BCD_MAX = 9;

    function automatic int max_pos(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int max_neg_mag(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Operand bus from the entry front end to the adder/subtractor.
interface operand_entry_if #(
    parameter int W = 6
);
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         a_valid;
    logic         b_valid;
    logic         ready;

    modport master (output opA, output opB, output a_valid, output b_valid, output ready);
    modport slave  (input  opA, input  opB, input  a_valid, input  b_valid, input  ready);
endinterface

// File: rtl/press_detect.sv
// Synchronizes a raw active-low pushbutton and emits a one-cycle pulse on
// each press (1->0 transition of the synchronized level).
module press_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Flops reset to the released level so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // value, giving a true shift chain rather than a single flop.
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/operand_entry.sv
// Keys in two signed decimal operands (sign + two BCD digits each) from
// switches and a pushbutton, and presents them as W-bit two's complement.
module operand_entry
    import calc_pkg::*;
#(
    parameter int W           = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      digit_in,
    input  logic            sign_in,
    input  logic            enter_n,
    operand_entry_if.master ops,
    output logic            err,
    output logic [2:0]      stage,
    output logic [3:0]      tens_shadow
);

    localparam logic [6:0] MAX_POS = 7'(max_pos(W));
    localparam logic [6:0] MAX_NEG = 7'(max_neg_mag(W));

    entry_state_t state_q, state_d;
    logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic         a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic         ready_q, ready_d, err_q, err_d;
    logic [3:0]   tens_q, tens_d;

    logic         press;
    logic         digit_ok;
    logic         in_range;
    logic [6:0]   mag;
    logic [W-1:0] value;

    press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_press (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (enter_n),
        .press   (press)
    );

    assign digit_ok = digit_in <= 4'(BCD_MAX);
    assign mag      = 7'(tens_q) * 7'd10 + 7'(digit_in);
    assign in_range = sign_in ? (mag <= MAX_NEG) : (mag <= MAX_POS);
    // Negation in 7 bits then truncation gives -2^(W-1) for the most negative
    // magnitude and plain 0 for a negative zero.
    assign value    = W'(sign_in ? 7'd0 - mag : mag);

    always_comb begin
        // NOTE: every target gets a default before any branch so no path
        // leaves a variable unassigned and infers a latch.
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        err_d     = err_q;
        tens_d    = tens_q;
        ready_d   = 1'b0;

        if (press) begin
            case (state_q)
                A_TENS, B_TENS: begin
                    if (digit_ok) begin
                        tens_d = digit_in;
                        err_d  = 1'b0;
                        if (state_q == A_TENS) state_d = A_ONES;
                        else                   state_d = B_ONES;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                A_ONES, B_ONES: begin
                    if (!digit_ok) begin
                        err_d = 1'b1;
                    end else if (!in_range) begin
                        err_d = 1'b1;
                        if (state_q == A_ONES) state_d = A_TENS;
                        else                   state_d = B_TENS;
                    end else begin
                        err_d = 1'b0;
                        if (state_q == A_ONES) begin
                            opa_d     = value;
                            a_valid_d = 1'b1;
                            state_d   = B_TENS;
                        end else begin
                            opb_d     = value;
                            b_valid_d = 1'b1;
                            ready_d   = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    a_valid_d = 1'b0;
                    b_valid_d = 1'b0;
                    err_d     = 1'b0;
                    tens_d    = 4'd0;
                    state_d   = A_TENS;
                end
                default: state_d = A_TENS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= A_TENS;
            opa_q     <= '0;
            opb_q     <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            tens_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            tens_q    <= tens_d;
        end
    end

    assign ops.opA     = opa_q;
    assign ops.opB     = opb_q;
    assign ops.a_valid = a_valid_q;
    assign ops.b_valid = b_valid_q;
    assign ops.ready   = ready_q;
    assign err         = err_q;
    assign stage       = state_q;
    assign tens_shadow = tens_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed test-plan steps followed by
// random key presses, all compared against a decimal-arithmetic entry model.
module tb_operand_entry;

    localparam int W = 6;

    logic       clk;
    logic       reset_n;
    logic [3:0] digit_in;
    logic       sign_in;
    logic       enter_n;
    logic       err;
    logic [2:0] stage;
    logic [3:0] tens_shadow;

    operand_entry_if #(.W(W)) bus ();

    operand_entry #(.W(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_in    (digit_in),
        .sign_in     (sign_in),
        .enter_n     (enter_n),
        .ops         (bus),
        .err         (err),
        .stage       (stage),
        .tens_shadow (tens_shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: entry position 0..3 walks A tens, A ones, B tens, B ones; 4 = both entered.
    int m_pos, m_tens, m_opa, m_opb;
    bit m_av, m_bv, m_err, m_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_tens = 0; m_opa = 0; m_opb = 0;
        m_av = 0; m_bv = 0; m_err = 0; m_ready = 0;
    endtask

    task automatic model_press(input int d, input int s);
        int mag, lim, val;
        m_ready = 0;
        if (m_pos == 4) begin
            m_av = 0; m_bv = 0; m_err = 0; m_tens = 0; m_pos = 0;
            return;
        end
        if (d > 9) begin
            m_err = 1;
            return;
        end
        if (m_pos % 2 == 0) begin
            m_tens = d; m_err = 0; m_pos++;
            return;
        end
        mag = m_tens * 10 + d;
        lim = s ? (1 << (W - 1)) : (1 << (W - 1)) - 1;
        if (mag > lim) begin
            m_err = 1; m_pos--;
            return;
        end
        val = (s ? -mag : mag) & ((1 << W) - 1);
        m_err = 0;
        if (m_pos == 1) begin
            m_opa = val; m_av = 1;
        end else begin
            m_opb = val; m_bv = 1; m_ready = 1;
        end
        m_pos++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".stage"},   32'(stage),       32'(m_pos));
        check({tag, ".tens"},    32'(tens_shadow), 32'(m_tens));
        check({tag, ".opA"},     32'(bus.opA),     32'(m_opa));
        check({tag, ".opB"},     32'(bus.opB),     32'(m_opb));
        check({tag, ".a_valid"}, 32'(bus.a_valid), 32'(m_av));
        check({tag, ".b_valid"}, 32'(bus.b_valid), 32'(m_bv));
        check({tag, ".err"},     32'(err),         32'(m_err));
        check({tag, ".ready"},   32'(bus.ready),   32'(m_ready));
    endtask

    // Called right after a sample point (#1 past a rising edge).
    task automatic do_press(input string tag, input int d, input int s);
        digit_in = 4'(d);
        sign_in  = s[0];
        enter_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_press(d, s);
        check_all(tag);
        @(posedge clk);
        #1;
        m_ready = 0;
        check({tag, ".ready_drop"}, 32'(bus.ready), 32'd0);
        enter_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all({tag, ".release"});
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        enter_n  = 1'b1;
        digit_in = 4'd0;
        sign_in  = 1'b0;
        model_reset();
        #23 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Held button: one press, visible after the third rising edge.
        digit_in = 4'd3;
        enter_n  = 1'b0;
        @(posedge clk); #1;
        check("hold.edge1.stage", 32'(stage), 32'd0);
        @(posedge clk); #1;
        check("hold.edge2.stage", 32'(stage), 32'd0);
        @(posedge clk); #1;
        model_press(3, 0);
        check_all("hold.edge3");
        repeat (17) @(posedge clk);
        #1;
        check_all("hold.20cyc");
        enter_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all("hold.release");

        // A = +25, B = -32 (restart A from tens after the held press).
        do_press("a_ones_bad", 9, 0);
        do_press("a25.tens", 2, 0);
        do_press("a25.ones", 5, 0);
        check("a25.const", 32'(bus.opA), 32'(6'b011001));
        do_press("bm32.tens", 3, 1);
        do_press("bm32.ones", 2, 1);
        check("bm32.const", 32'(bus.opB), 32'(6'b100000));
        check("bm32.done",  32'(stage),   32'd4);
        do_press("done.press", 7, 0);
        check("done.opA_kept", 32'(bus.opA), 32'(6'b011001));

        // +32 out of range, then +31 at the positive limit.
        do_press("ap32.tens", 3, 0);
        do_press("ap32.ones", 2, 0);
        check("ap32.err",   32'(err),         32'd1);
        check("ap32.tens3", 32'(tens_shadow), 32'd3);
        do_press("ap31.tens", 3, 0);
        do_press("ap31.ones", 1, 0);
        check("ap31.const", 32'(bus.opA), 32'(6'b011111));

        // Finish B, leave DONE, then bad digits at A_TENS / A_ONES and -00.
        do_press("b7.tens", 0, 0);
        do_press("b7.ones", 7, 0);
        do_press("done2", 0, 0);
        do_press("tens_hexC", 12, 0);
        check("tens_hexC.stage", 32'(stage), 32'd0);
        do_press("z.tens", 0, 1);
        do_press("ones_hexA", 10, 1);
        check("ones_hexA.stage", 32'(stage), 32'd1);
        do_press("negzero", 0, 1);
        check("negzero.opA", 32'(bus.opA), 32'd0);

        // Reach B_ONES with A = 25, then asynchronous reset mid-cycle.
        do_press("b.tens", 1, 1);
        do_press("b.ones", 5, 1);
        do_press("done3", 0, 0);
        do_press("r.a.tens", 2, 0);
        do_press("r.a.ones", 5, 0);
        do_press("r.b.tens", 1, 0);
        check("r.pre.stage", 32'(stage), 32'd3);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("post_reset");

        // Random presses, mostly legal digits with occasional non-BCD codes.
        for (int i = 0; i < 80; i++) begin
            int d, s;
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            s = int'($urandom_range(0, 1));
            do_press($sformatf("rnd%0d", i), d, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
